// File: rtl/apb_uart_fifo_bridge_if.sv
// APB slave bus plus UART rx/tx byte streams seen by apb_uart_fifo_bridge.
interface apb_uart_fifo_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  tx_ready;
  logic                  tx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  irq;

  modport slave (
    input  paddr, pselx, penable, pwrite, pwdata, rx_valid, rx_data, tx_ready,
    output pready, prdata, pslverr, rx_ready, tx_valid, tx_data, irq
  );

  modport master (
    output paddr, pselx, penable, pwrite, pwdata, rx_valid, rx_data, tx_ready,
    input  pready, prdata, pslverr, rx_ready, tx_valid, tx_data, irq
  );
endinterface

// File: rtl/apb_uart_fifo_bridge.sv
// Zero-wait-state APB slave with RX/TX byte FIFOs, TX send FSM, overrun flag and level irq.
// Optional internal TX->RX loopback (CTRL bit5) is built only when APB_UART_LOOPBACK_EN is defined.

module apb_uart_fifo_bridge_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [DW-1:0] push_dat_i,
  input  logic          pop_i,
  output logic [DW-1:0] head_o,
  output logic          empty_o,
  output logic          full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end
endmodule

module apb_uart_fifo_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int RX_DEPTH   = 16,
  parameter int TX_DEPTH   = 16
) (
  input logic                   pclk,
  input logic                   prstn,
  apb_uart_fifo_bridge_if.slave bus
);
  localparam logic [3:0] A_TXDATA = 4'h0;
  localparam logic [3:0] A_RXDATA = 4'h1;
  localparam logic [3:0] A_STATUS = 4'h2;
  localparam logic [3:0] A_CTRL   = 4'h3;

  typedef enum logic {S_IDLE, S_SEND} tx_state_e;

  logic [ADDR_WIDTH-1:0] paddr_w;
  logic [3:0]            addr;
  logic                  acc, wr, rd, err;
  logic [DATA_WIDTH-1:0] rdata, status, ctrl_rd;
  logic [2:0]            ctrl_q, ctrl_d;    // {irq_en, rx_en, tx_en}
  logic                  ctrl_wr, clr_ov, flush;
  logic                  ov_q, ov_d, irq_q, rx_rdy_q, loopback;
  tx_state_e             state_q, state_d;
  logic                  tx_vld_q, tx_vld_d, tx_pop, tx_fire;
  logic [DATA_WIDTH-1:0] tx_dat_q, tx_dat_d;
  logic [DATA_WIDTH-1:0] rx_head, tx_head, rx_in_dat;
  logic                  rx_empty, rx_full, tx_empty, tx_full, rx_in_vld, rx_pop, tx_push;
  logic                  unused_bits;

  assign paddr_w     = bus.paddr;
  assign addr        = paddr_w[3:0];
  assign unused_bits = ^{paddr_w, bus.pwdata};
  assign acc         = bus.pselx & bus.penable;
  assign wr          = acc & bus.pwrite;
  assign rd          = acc & ~bus.pwrite;

  assign ctrl_wr = wr & (addr == A_CTRL);
  assign clr_ov  = ctrl_wr & bus.pwdata[3];
  assign flush   = ctrl_wr & bus.pwdata[4];
  assign ctrl_d  = ctrl_wr ? bus.pwdata[2:0] : ctrl_q;
  assign tx_push = wr & (addr == A_TXDATA);
  assign rx_pop  = rd & (addr == A_RXDATA);

`ifdef APB_UART_LOOPBACK_EN
  logic lb_q;
  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn)       lb_q <= 1'b0;
    else if (ctrl_wr) lb_q <= bus.pwdata[5];
  end
  assign loopback = lb_q;
`else
  assign loopback = 1'b0;
`endif

  assign status  = {{(DATA_WIDTH-5){1'b0}}, ov_q, tx_full, tx_empty, rx_full, ~rx_empty};
  assign ctrl_rd = {{(DATA_WIDTH-6){1'b0}}, loopback, 2'b00, ctrl_q};

  // Errors use pre-edge full/empty, so a same-cycle pop never rescues a push.
  always_comb begin
    err   = 1'b0;
    rdata = '0;
    case (addr)
      A_TXDATA: err = ~bus.pwrite | tx_full;
      A_RXDATA: begin
        err = bus.pwrite | rx_empty;
        if (!rx_empty) rdata = rx_head;
      end
      A_STATUS: begin
        err   = bus.pwrite;
        rdata = status;
      end
      A_CTRL:   rdata = ctrl_rd;
      default:  err = 1'b1;
    endcase
  end

  assign bus.pready  = acc;
  assign bus.pslverr = acc & err;
  assign bus.prdata  = rd ? rdata : '0;

  always_comb begin
    state_d  = state_q;
    tx_vld_d = tx_vld_q;
    tx_dat_d = tx_dat_q;
    tx_pop   = 1'b0;
    tx_fire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctrl_q[0] && !tx_empty) begin
          tx_dat_d = tx_head;
          tx_vld_d = 1'b1;
          tx_pop   = 1'b1;
          state_d  = S_SEND;
        end
      end
      S_SEND: begin
        // tx_en is only sampled at handshake boundaries, so a byte in flight always completes.
        if (bus.tx_ready || loopback) begin
          tx_fire = 1'b1;
          if (ctrl_q[0] && !tx_empty) begin
            tx_dat_d = tx_head;
            tx_pop   = 1'b1;
          end else begin
            tx_vld_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_in_vld = (bus.rx_valid & bus.rx_ready) | (tx_fire & loopback);
  assign rx_in_dat = loopback ? tx_dat_q : bus.rx_data;
  assign ov_d      = (rx_in_vld & rx_full) | (ov_q & ~clr_ov);

  always_ff @(posedge pclk or negedge prstn) begin
    if (!prstn) begin
      ctrl_q   <= 3'b011;
      ov_q     <= 1'b0;
      irq_q    <= 1'b0;
      rx_rdy_q <= 1'b0;
      state_q  <= S_IDLE;
      tx_vld_q <= 1'b0;
      tx_dat_q <= '0;
    end else begin
      ctrl_q   <= ctrl_d;
      ov_q     <= ov_d;
      irq_q    <= ctrl_q[2] & (~rx_empty | ov_q);
      rx_rdy_q <= ctrl_q[1];
      state_q  <= state_d;
      tx_vld_q <= tx_vld_d;
      tx_dat_q <= tx_dat_d;
    end
  end

  assign bus.rx_ready = rx_rdy_q & ~loopback;
  assign bus.tx_valid = tx_vld_q & ~loopback;
  assign bus.tx_data  = tx_dat_q;
  assign bus.irq      = irq_q;

  apb_uart_fifo_bridge_fifo #(.DW(DATA_WIDTH), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk_i(pclk), .rst_ni(prstn), .flush_i(flush),
    .push_i(rx_in_vld), .push_dat_i(rx_in_dat), .pop_i(rx_pop),
    .head_o(rx_head), .empty_o(rx_empty), .full_o(rx_full)
  );

  apb_uart_fifo_bridge_fifo #(.DW(DATA_WIDTH), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk_i(pclk), .rst_ni(prstn), .flush_i(flush),
    .push_i(tx_push), .push_dat_i(bus.pwdata), .pop_i(tx_pop),
    .head_o(tx_head), .empty_o(tx_empty), .full_o(tx_full)
  );
endmodule

// File: tb/tb_apb_uart_fifo_bridge.sv
// Scoreboard bench for apb_uart_fifo_bridge: APB responses and TX bytes are queued at issue and popped by a monitor.
// Loopback checks are compiled in when APB_UART_LOOPBACK_EN is defined.
module tb_apb_uart_fifo_bridge;
  localparam logic [3:0] A_TX = 4'h0, A_RX = 4'h1, A_ST = 4'h2, A_CT = 4'h3;

  logic pclk = 1'b0;
  logic prstn;
  always #5 pclk = ~pclk;

  apb_uart_fifo_bridge_if #(.ADDR_WIDTH(32), .DATA_WIDTH(8)) bus ();

  apb_uart_fifo_bridge #(
    .ADDR_WIDTH(32), .DATA_WIDTH(8), .RX_DEPTH(16), .TX_DEPTH(16)
  ) dut (
    .pclk(pclk), .prstn(prstn), .bus(bus)
  );

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    string      name;
  } apb_exp_t;

  apb_exp_t   apb_q[$];
  logic [7:0] tx_q[$];
  int         checks = 0;
  int         failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Expects to be called at posedge+1; returns at posedge+1 just after the commit edge.
  task automatic apb(input string name, input logic w, input logic [3:0] a,
                     input logic [7:0] wd, input logic [7:0] exp_rd, input logic exp_err);
    apb_exp_t e;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.name  = name;
    apb_q.push_back(e);
    bus.pselx   = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = w;
    bus.paddr   = {28'h0, a};
    bus.pwdata  = wd;
    @(posedge pclk); #1;
    bus.penable = 1'b1;
    @(posedge pclk); #1;
    bus.pselx   = 1'b0;
    bus.penable = 1'b0;
    bus.pwrite  = 1'b0;
  endtask

  task automatic wr(input string name, input logic [3:0] a, input logic [7:0] d, input logic err);
    apb(name, 1'b1, a, d, 8'h00, err);
  endtask

  task automatic rd(input string name, input logic [3:0] a, input logic [7:0] exp, input logic err);
    apb(name, 1'b0, a, 8'h00, exp, err);
  endtask

  task automatic rx_push(input logic [7:0] d);
    bus.rx_valid = 1'b1;
    bus.rx_data  = d;
    @(posedge pclk); #1;
    bus.rx_valid = 1'b0;
  endtask

  always @(negedge pclk) begin
    apb_exp_t   e;
    logic [7:0] t;
    if (prstn) begin
      if (bus.pready) begin
        checks++;
        if (apb_q.size() == 0) begin
          failures++;
          $display("FAIL apb_unexpected: got rdata=0x%0h err=%0b, expected no transfer", bus.prdata, bus.pslverr);
        end else begin
          e = apb_q.pop_front();
          if (bus.prdata !== e.rdata || bus.pslverr !== e.err) begin
            failures++;
            $display("FAIL %s: got rdata=0x%0h err=%0b, expected rdata=0x%0h err=%0b",
                     e.name, bus.prdata, bus.pslverr, e.rdata, e.err);
          end
        end
      end
      if (bus.tx_valid && bus.tx_ready) begin
        checks++;
        if (tx_q.size() == 0) begin
          failures++;
          $display("FAIL tx_unexpected: got tx_data=0x%0h, expected no byte", bus.tx_data);
        end else begin
          t = tx_q.pop_front();
          if (bus.tx_data !== t) begin
            failures++;
            $display("FAIL tx_byte: got 0x%0h, expected 0x%0h", bus.tx_data, t);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion before 100000ns");
    $fatal(1);
  end

  initial begin
    prstn        = 1'b0;
    bus.pselx    = 1'b0;
    bus.penable  = 1'b0;
    bus.pwrite   = 1'b0;
    bus.paddr    = '0;
    bus.pwdata   = '0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = '0;
    bus.tx_ready = 1'b0;
    #12;
    chk("rst_pready",   bus.pready,   0);
    chk("rst_prdata",   bus.prdata,   0);
    chk("rst_pslverr",  bus.pslverr,  0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data",  bus.tx_data,  0);
    chk("rst_rx_ready", bus.rx_ready, 0);
    chk("rst_irq",      bus.irq,      0);
    #10 prstn = 1'b1;
    @(posedge pclk); #1;
    chk("rx_ready_after_rst", bus.rx_ready, 1);
    rd("ctrl_reset", A_CT, 8'h03, 1'b0);

    // Single byte: tx_valid rises one edge after the commit edge.
    bus.tx_ready = 1'b1;
    tx_q.push_back(8'hA5);
    wr("tx_a5", A_TX, 8'hA5, 1'b0);
    chk("tx_valid_at_commit", bus.tx_valid, 0);
    @(posedge pclk); #1;
    chk("tx_valid_e1", bus.tx_valid, 1);
    chk("tx_data_e1",  bus.tx_data,  8'hA5);
    rd("status_after_tx", A_ST, 8'h04, 1'b0);

    // The first byte leaves the FIFO for the SEND register, so the 17th write fills it and the 18th overflows.
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tx_q.push_back(8'(i));
      wr("tx_fill", A_TX, 8'(i), 1'b0);
    end
    tx_q.push_back(8'h55);
    wr("tx_fill_last", A_TX, 8'h55, 1'b0);
    wr("tx_overflow", A_TX, 8'h66, 1'b1);
    rd("status_tx_full", A_ST, 8'h08, 1'b0);
    repeat (3) begin
      @(posedge pclk); #1;
      chk("tx_hold_valid", bus.tx_valid, 1);
      chk("tx_hold_data",  bus.tx_data,  8'h00);
    end
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge pclk);
      chk("tx_no_gap", bus.tx_valid, 1);
    end
    @(negedge pclk);
    chk("tx_drained_idle", bus.tx_valid, 0);
    @(posedge pclk); #1;

    // RX overrun with irq enabled.
    wr("ctrl_irq_en", A_CT, 8'h07, 1'b0);
    for (int i = 1; i <= 17; i++) rx_push(8'(i));
    @(posedge pclk); #1;
    chk("irq_rx_full", bus.irq, 1);
    rd("status_rx_overrun", A_ST, 8'h17, 1'b0);
    for (int i = 1; i <= 16; i++) rd("rx_byte", A_RX, 8'(i), 1'b0);
    rd("rx_empty_read", A_RX, 8'h00, 1'b1);
    wr("ctrl_clr_ov", A_CT, 8'h0F, 1'b0);
    rd("status_ov_cleared", A_ST, 8'h04, 1'b0);
    rd("ctrl_after_clr", A_CT, 8'h07, 1'b0);
    chk("irq_cleared", bus.irq, 0);

    // Decode errors leave CTRL untouched.
    rd("rd_unmapped", 4'h7, 8'h00, 1'b1);
    wr("wr_status", A_ST, 8'hFF, 1'b1);
    rd("rd_txdata", A_TX, 8'h00, 1'b1);
    wr("wr_rxdata", A_RX, 8'h00, 1'b1);
    wr("wr_unmapped", 4'hC, 8'h00, 1'b1);
    rd("ctrl_unchanged", A_CT, 8'h07, 1'b0);

    // RX full, incoming byte and RXDATA pop in the same cycle.
    for (int i = 0; i < 16; i++) rx_push(8'(8'h20 + i));
    fork
      rd("rx_same_cycle", A_RX, 8'h20, 1'b0);
      begin
        @(posedge pclk); #1;
        rx_push(8'h99);
      end
    join
    rd("status_same_cycle", A_ST, 8'h15, 1'b0);
    for (int i = 1; i < 16; i++) rd("rx_after_drop", A_RX, 8'(8'h20 + i), 1'b0);
    rd("rx_count_15", A_RX, 8'h00, 1'b1);
    wr("ctrl_clr_ov2", A_CT, 8'h0F, 1'b0);

    // Flush empties both FIFOs; with tx_en=0 nothing is sent.
    wr("ctrl_tx_off", A_CT, 8'h06, 1'b0);
    wr("tx_hold1", A_TX, 8'h11, 1'b0);
    wr("tx_hold2", A_TX, 8'h22, 1'b0);
    rx_push(8'h77);
    rx_push(8'h78);
    rd("status_pre_flush", A_ST, 8'h01, 1'b0);
    wr("ctrl_flush", A_CT, 8'h16, 1'b0);
    rd("status_post_flush", A_ST, 8'h04, 1'b0);
    rd("rx_after_flush", A_RX, 8'h00, 1'b1);
    wr("ctrl_tx_on", A_CT, 8'h07, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    chk("tx_idle_after_flush", bus.tx_valid, 0);

`ifdef APB_UART_LOOPBACK_EN
    wr("ctrl_loopback", A_CT, 8'h23, 1'b0);
    rd("ctrl_lb_read", A_CT, 8'h23, 1'b0);
    wr("tx_lb", A_TX, 8'h3C, 1'b0);
    repeat (3) begin
      @(posedge pclk); #1;
      chk("lb_tx_valid", bus.tx_valid, 0);
      chk("lb_rx_ready", bus.rx_ready, 0);
    end
    rd("lb_rx_byte", A_RX, 8'h3C, 1'b0);
    wr("ctrl_lb_off", A_CT, 8'h07, 1'b0);
`else
    wr("ctrl_bit5", A_CT, 8'h27, 1'b0);
    rd("ctrl_bit5_ignored", A_CT, 8'h07, 1'b0);
`endif

    // Asynchronous reset in the middle of a pending tx byte.
    bus.tx_ready = 1'b0;
    wr("tx_pending", A_TX, 8'h5A, 1'b0);
    rx_push(8'h44);
    @(posedge pclk); #1;
    chk("pending_valid", bus.tx_valid, 1);
    chk("pending_irq",   bus.irq,      1);
    #2 prstn = 1'b0;
    #1;
    chk("midrst_tx_valid", bus.tx_valid, 0);
    chk("midrst_tx_data",  bus.tx_data,  0);
    chk("midrst_irq",      bus.irq,      0);
    chk("midrst_rx_ready", bus.rx_ready, 0);
    @(posedge pclk); #1;
    prstn = 1'b1;
    @(posedge pclk); #1;
    rd("status_after_rst", A_ST, 8'h04, 1'b0);
    rd("ctrl_after_rst",   A_CT, 8'h03, 1'b0);
    rd("rx_after_rst",     A_RX, 8'h00, 1'b1);
    chk("tx_after_rst", bus.tx_valid, 0);

    repeat (3) @(posedge pclk);
    chk("apb_queue_drained", apb_q.size(), 0);
    chk("tx_queue_drained",  tx_q.size(),  0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
